// File: rtl/dff_pkg.sv
// Shared constants for the dff register slice: default and maximum legal data width.
package dff_pkg;

  localparam int dff_width_default_c = 32'sd1;
  localparam int dff_width_max_c     = 32'sd64;

endpackage : dff_pkg

// File: rtl/dff.sv
// Enable-gated register with asynchronous active-low reset to reset_val_p.
// Optional synchronous clear port clear_i is added when DFF_SYNC_CLEAR_EN is defined.
module dff
  import dff_pkg::*;
#(
  parameter int                 width_p     = dff_width_default_c,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
`ifdef DFF_SYNC_CLEAR_EN
  input  logic               clear_i,
`endif
  input  logic               en_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] q_r;

  if ((width_p < 32'sd1) || (width_p > dff_width_max_c)) begin : g_bad_width
    $error("dff: width_p=%0d outside legal range 1..%0d", width_p, dff_width_max_c);
  end

  // Storage flop: reset dominates, then synchronous clear (if built in), then enable.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q_r <= reset_val_p;
    end
`ifdef DFF_SYNC_CLEAR_EN
    else if (clear_i) begin
      q_r <= reset_val_p;
    end
`endif
    else if (en_i) begin
      q_r <= d_i;
    end else begin
      q_r <= q_r;
    end
  end

  assign q_o = q_r;

endmodule : dff

// File: tb/tb_dff.sv
// Self-checking bench for dff: a 1-bit default instance and an 8-bit instance with reset value 8'hA5.
// Clear-port checks are compiled in only when DFF_SYNC_CLEAR_EN is defined.
module tb_dff;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  logic       clk;
  logic       reset_i;
  logic       en1, d1, q1;
  logic       en8;
  logic [7:0] d8, q8;
  logic       clr1, clr8;
  int         n_vec;
  int         n_err;
  logic       model_q;

  dff u_dff1 (
    .clk_i   (clk),
    .reset_i (reset_i),
`ifdef DFF_SYNC_CLEAR_EN
    .clear_i (clr1),
`endif
    .en_i    (en1),
    .d_i     (d1),
    .q_o     (q1)
  );

  dff #(
    .width_p     (8),
    .reset_val_p (8'hA5)
  ) u_dff8 (
    .clk_i   (clk),
    .reset_i (reset_i),
`ifdef DFF_SYNC_CLEAR_EN
    .clear_i (clr8),
`endif
    .en_i    (en8),
    .d_i     (d8),
    .q_o     (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{1'b1, 8'h3C, 8'h3C};
    tbl[1]  = '{1'b0, 8'hFF, 8'h3C};
    tbl[2]  = '{1'b1, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h55, 8'h00};
    tbl[4]  = '{1'b1, 8'hFF, 8'hFF};
    tbl[5]  = '{1'b1, 8'h81, 8'h81};
    tbl[6]  = '{1'b0, 8'h7E, 8'h81};
    tbl[7]  = '{1'b0, 8'h00, 8'h81};
    tbl[8]  = '{1'b1, 8'h5A, 8'h5A};
    tbl[9]  = '{1'b1, 8'hA5, 8'hA5};
    tbl[10] = '{1'b0, 8'h12, 8'hA5};
    tbl[11] = '{1'b1, 8'hC3, 8'hC3};

    n_vec = 0;
    n_err = 0;
    clr1 = 1'b0;
    clr8 = 1'b0;
    reset_i = 1'b1;
    en1 = 1'b1;
    d1  = 1'b1;
    en8 = 1'b1;
    d8  = 8'h3C;

    // Reset asserted before any clock edge must act immediately.
    #1 reset_i = 1'b0;
    #1;
    check("rst_async_q1", 64'(q1), 64'h0);
    check("rst_async_q8", 64'(q8), 64'hA5);
    tick();
    check("rst_edge_q1", 64'(q1), 64'h0);
    check("rst_edge_q8", 64'(q8), 64'hA5);

    // First enabled edge after release loads d.
    @(negedge clk) reset_i = 1'b1;
    tick();
    check("release_load_q1", 64'(q1), 64'h1);
    check("release_load_q8", 64'(q8), 64'h3C);

    // Hold for three edges with en=0, d=0.
    @(negedge clk);
    en1 = 1'b0;
    d1  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q1", 64'(q1), 64'h1);
    end

    // Inputs changing between edges must not disturb q.
    @(negedge clk);
    en1 = 1'b1;
    d1  = 1'b0;
    tick();
    check("load0_q1", 64'(q1), 64'h0);
    d1 = 1'b1;
    @(negedge clk);
    check("midcycle_change_q1", 64'(q1), 64'h0);
    tick();
    check("load1_q1", 64'(q1), 64'h1);

    // Reset asserted mid-cycle while q=1 clears before the next edge.
    #2 reset_i = 1'b0;
    #1;
    check("midcycle_rst_q1", 64'(q1), 64'h0);
    check("midcycle_rst_q8", 64'(q8), 64'hA5);

    // After release, q stays at reset value until the first enabled edge.
    @(negedge clk);
    reset_i = 1'b1;
    en1 = 1'b0;
    d1  = 1'b1;
    en8 = 1'b0;
    d8  = 8'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_idle_q1", 64'(q1), 64'h0);
      check("post_rst_idle_q8", 64'(q8), 64'hA5);
    end
    @(negedge clk) en1 = 1'b1;
    tick();
    check("post_rst_first_load_q1", 64'(q1), 64'h1);

    // Table-driven vectors on the 8-bit instance, starting from q8=8'hA5.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en8 = tbl[i].en;
      d8  = tbl[i].d;
      tick();
      check($sformatf("tbl8[%0d]", i), 64'(q8), 64'(tbl[i].exp_q));
    end

    // Random enable/data pairs on the 1-bit instance against a load/hold model.
    model_q = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en1 = 1'($urandom_range(1, 0));
      d1  = 1'($urandom_range(1, 0));
      if (en1) model_q = d1;
      tick();
      check($sformatf("rand1[%0d]", i), 64'(q1), 64'(model_q));
    end

`ifdef DFF_SYNC_CLEAR_EN
    // Clear overrides enable and loads the reset value.
    @(negedge clk);
    en1 = 1'b1;
    d1  = 1'b1;
    en8 = 1'b1;
    d8  = 8'h0F;
    tick();
    check("pre_clear_q1", 64'(q1), 64'h1);
    check("pre_clear_q8", 64'(q8), 64'h0F);
    @(negedge clk);
    clr1 = 1'b1;
    clr8 = 1'b1;
    tick();
    check("clear_q1", 64'(q1), 64'h0);
    check("clear_q8", 64'(q8), 64'hA5);
    @(negedge clk);
    clr1 = 1'b0;
    clr8 = 1'b0;
    tick();
    check("post_clear_load_q1", 64'(q1), 64'h1);
    check("post_clear_load_q8", 64'(q8), 64'h0F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_dff

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 The module SHALL expose parameter width_p, default 1, meaning data width in bits (legal range 1..64).
REQ-002 The module SHALL expose parameter reset_val_p, default all-zeros, meaning the value loaded into q_o during reset (width_p bits).
REQ-003 The module SHALL have port clk_i  input  1  rising-edge clock.
REQ-004 The module SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port en_i  input  1  load enable, active-high.
REQ-006 The module SHALL have port d_i  input  width_p  data to capture.
REQ-007 The module SHALL have port q_o  output  width_p  registered data, driven directly from flops.

Function
REQ-008 On a rising clk_i edge with reset_i high and en_i=1, q_o SHALL take d_i, visible one cycle later (latency 1).
REQ-009 On a rising clk_i edge with reset_i high and en_i=0, q_o SHALL hold its previous value.
REQ-010 q_o SHALL have no combinational path from any input.
REQ-011 en_i and d_i SHALL be sampled only at the rising edge; changes between edges SHALL NOT affect q_o.
REQ-012 All width_p bits SHALL update together under the same en_i; there is no per-bit enable.
REQ-013 X or Z on en_i while out of reset SHALL NOT be required to yield a defined q_o; benches drive known values only.

Reset
REQ-014 While reset_i=0, q_o SHALL equal reset_val_p, regardless of clk_i, en_i and d_i.
REQ-015 Assertion of reset_i SHALL force q_o to reset_val_p immediately, without waiting for a clock edge, including mid-operation.
REQ-016 When reset_i and a rising clk_i edge occur simultaneously, reset SHALL take priority.
REQ-017 After reset_i rises, the first rising edge with en_i=1 SHALL load d_i; until then q_o SHALL remain reset_val_p.

Configuration
REQ-018 When macro DFF_SYNC_CLEAR_EN is defined, the module SHALL add input clear_i (1 bit, active-high), and a rising edge with clear_i=1 SHALL load reset_val_p into q_o regardless of en_i.
REQ-019 With DFF_SYNC_CLEAR_EN defined, clear_i SHALL take priority over en_i, and reset_i SHALL take priority over clear_i.
REQ-020 Without DFF_SYNC_CLEAR_EN, port clear_i SHALL NOT exist, and behaviour SHALL be exactly REQ-008..REQ-017.

Structure
REQ-021 Shared package dff_pkg SHALL hold the default width constant (1) and the maximum legal width constant (64).
REQ-022 The design SHALL consist of a single module with one always_ff process; no sub-module is required.
REQ-023 An elaboration-time check SHALL reject width_p < 1 or width_p > 64.

Verification
REQ-024 Hold reset_i=0 for 1 cycle with d_i=1 and en_i=1: q_o=0 throughout; after release, the next edge gives q_o=1.
REQ-025 With reset_i=1, q_o=1, en_i=0 and d_i=0 for 3 edges: q_o stays 1.
REQ-026 Drive 20 random {en_i,d_i} pairs at the clock negedge: q_o matches the golden model (load when en_i=1, else hold) at every posedge.
REQ-027 Assert reset_i=0 mid-cycle while q_o=1: q_o=0 before the next posedge.
REQ-028 With width_p=8, reset_val_p=8'hA5, en_i=1 and d_i=8'h3C: q_o=8'hA5 in reset, then 8'h3C one edge after release.
REQ-029 With DFF_SYNC_CLEAR_EN defined, q_o=1 and clear_i=1, en_i=1, d_i=1: q_o=0 at the next edge.
